fwd_regfile: RTL



---
 rtl/fwd_regfile_pkg.sv | 8 +
 rtl/pend_counter.sv | 40 ++++
 rtl/fwd_regfile.sv | 92 +++++++++
 3 files changed

// File: rtl/fwd_regfile_pkg.sv
// Shared CPU constants for the forwarding register file.
package fwd_regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned REG_ZERO   = 0;

endpackage : fwd_regfile_pkg

// File: rtl/pend_counter.sv
// Saturating up/down count of outstanding writers for one register.
module pend_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             dec_eff;

  // A write-back with nothing outstanding must not underflow.
  assign dec_eff = dec && (count_q != '0);

  // Next count: inc or dec alone moves it, both together cancel.
  always_comb begin
    count_d = count_q;
    if (inc && !dec_eff && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end else if (dec_eff && !inc) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : pend_counter

// File: rtl/fwd_regfile.sv
// Register file with write-back bypass and per-register pending-writer scoreboard.
module fwd_regfile
  import fwd_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned CNT_W  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_fwd,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_valid,
  input  logic                     iss_wr,
  input  logic [ADDR_W-1:0]        iss_dst,
  output logic                     stall
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [DEPTH-1:0][DATA_W-1:0] mem_d;
  logic [DEPTH-1:0][CNT_W-1:0]  pend_cnt;
  logic [NUM_RD-1:0]            hazard;
  logic                         wr_live;
  logic                         iss_go;

  // Writes to register zero are dropped entirely.
  assign wr_live = wr_en && (wr_addr != ZERO_ADDR);
  assign iss_go  = iss_valid && !stall && iss_wr;

  // Storage next state; entry zero is never written so it stays zero.
  always_comb begin
    mem_d = mem_q;
    if (wr_live) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Storage register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign pend_cnt[0] = '0;

  // One pending-writer counter per writable register.
  for (genvar r = 1; r < DEPTH; r++) begin : g_pend
    pend_counter #(
      .CNT_W (CNT_W)
    ) u_pend (
      .clk   (clk),
      .reset (reset),
      .inc   (iss_go && (iss_dst == ADDR_W'(r))),
      .dec   (wr_en && (wr_addr == ADDR_W'(r))),
      .count (pend_cnt[r])
    );
  end

  // Per-port bypass mux and source hazard detection.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              hit;
    assign addr = rd_addr[p*ADDR_W +: ADDR_W];
    assign hit  = wr_live && (wr_addr == addr);
    assign rd_data[p*DATA_W +: DATA_W] = hit ? wr_data : mem_q[addr];
    assign rd_fwd[p] = hit;
    // The last outstanding writer completing now is covered by the bypass.
    assign hazard[p] = (addr != ZERO_ADDR) && (pend_cnt[addr] != '0) &&
                       !((pend_cnt[addr] == CNT_W'(1)) && hit);
  end

  // Block issue on source hazards or a saturated destination counter.
  always_comb begin
    stall = 1'b0;
    if (iss_valid) begin
      stall = (|hazard) ||
              (iss_wr && (iss_dst != ZERO_ADDR) && (&pend_cnt[iss_dst]));
    end
  end

endmodule : fwd_regfile
